pipeline_hazard_sequencer: RTL and testbench

PIPELINE_HAZARD_SEQUENCER -- requirements
Module: pipeline_hazard_sequencer

---
 rtl/pipeline_hazard_sequencer_pkg.sv | 30 +++
 rtl/pipeline_hazard_sequencer_sat_counter.sv | 34 +++
 rtl/pipeline_hazard_sequencer.sv | 140 ++++++++++++++
 tb/tb_pipeline_hazard_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_sequencer_pkg.sv
// ============================================================================
// Module  : hazard_pkg
// Brief   : Shared types and constants for the pipeline hazard sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_e;

  localparam int CNT_W_DEFAULT = 16;
  localparam int FLUSH_MIN     = 1;
  localparam int FLUSH_MAX     = 7;
  localparam int CD_W          = 3;

  // Out-of-range flush lengths are clamped into the legal 1..7 window.
  function automatic int flush_cycles_legal(input int n);
    if (n < FLUSH_MIN) return FLUSH_MIN;
    if (n > FLUSH_MAX) return FLUSH_MAX;
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipeline_hazard_sequencer_sat_counter.sv
// ============================================================================
// Module  : sat_counter
// Brief   : Saturating up-counter with synchronous clear.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (inc_i && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_sequencer.sv
// ============================================================================
// Module  : pipeline_hazard_sequencer
// Brief   : Stall/flush/redirect control for a 5-stage pipeline with counters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pipeline_hazard_sequencer
  import hazard_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1D,
  input  logic [4:0]       rs2D,
  input  logic [4:0]       rdE,
  input  logic             MemReadE,
  input  logic             PCsrcE,
  input  logic [XLEN-1:0]  PCtargetE,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             cnt_clr,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             PCsel,
  output logic [XLEN-1:0]  PCredirect,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] lu_cnt,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] mw_cnt
);

  localparam int             FLUSH_EFF  = flush_cycles_legal(FLUSH_CYCLES);
  localparam logic [CD_W-1:0] FLUSH_LOAD = CD_W'(FLUSH_EFF - 1);

  state_e          state_q, state_d;
  logic [CD_W-1:0] cd_q, cd_d;

  logic freeze, branch, loaduse;
  logic lu_hit, br_hit, mw_hit;

  assign freeze  = dmem_req & ~dmem_ready;
  assign branch  = PCsrcE & ~freeze;
  assign loaduse = MemReadE & (rdE != 5'd0) & ((rdE == rs1D) | (rdE == rs2D))
                   & ~freeze & ~branch;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
      cd_q    <= '0;
    end else begin
      state_q <= state_d;
      cd_q    <= cd_d;
    end
  end

  // Outputs are forced low while reset is held so they drop without a clock.
  always_comb begin
    state_d    = state_q;
    cd_d       = cd_q;
    StallF     = 1'b0;
    StallD     = 1'b0;
    StallE     = 1'b0;
    StallM     = 1'b0;
    FlushD     = 1'b0;
    FlushE     = 1'b0;
    PCsel      = 1'b0;
    PCredirect = '0;
    lu_hit     = 1'b0;
    br_hit     = 1'b0;
    mw_hit     = 1'b0;
    if (rst) begin
      if (freeze) begin
        StallF  = 1'b1;
        StallD  = 1'b1;
        StallE  = 1'b1;
        StallM  = 1'b1;
        mw_hit  = 1'b1;
        state_d = ST_MEM_WAIT;
      end else if (branch) begin
        PCsel      = 1'b1;
        PCredirect = PCtargetE;
        FlushD     = 1'b1;
        FlushE     = 1'b1;
        br_hit     = 1'b1;
        cd_d       = FLUSH_LOAD;
        state_d    = (FLUSH_LOAD != '0) ? ST_FLUSH : ST_RUN;
      end else if (state_q == ST_FLUSH) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
        if (cd_q != '0) cd_d = cd_q - 1'b1;
        state_d = (cd_q <= CD_W'(1)) ? ST_RUN : ST_FLUSH;
      end else if (state_q == ST_MEM_WAIT) begin
        // Resume any flush sequence that the memory wait interrupted.
        state_d = (cd_q != '0) ? ST_FLUSH : ST_RUN;
      end else if (loaduse) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
        lu_hit = 1'b1;
      end
    end
  end

  assign state_o = state_q;

  sat_counter #(.WIDTH(CNT_W)) u_lu_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (lu_hit),
    .clr_i   (cnt_clr),
    .count_o (lu_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_br_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (br_hit),
    .clr_i   (cnt_clr),
    .count_o (br_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_mw_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (mw_hit),
    .clr_i   (cnt_clr),
    .count_o (mw_cnt)
  );

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_sequencer.sv
// ============================================================================
// Module  : tb_pipeline_hazard_sequencer
// Brief   : Directed self-checking bench for pipeline_hazard_sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pipeline_hazard_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1D, rs2D, rdE;
  logic        MemReadE, PCsrcE;
  logic [31:0] PCtargetE;
  logic        dmem_req, dmem_ready, cnt_clr;
  logic        StallF, StallD, StallE, StallM, FlushD, FlushE, PCsel;
  logic [31:0] PCredirect;
  logic [1:0]  state_o;
  logic [15:0] lu_cnt, br_cnt, mw_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_hazard_sequencer #(
    .XLEN(32), .FLUSH_CYCLES(2), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst),
    .rs1D(rs1D), .rs2D(rs2D), .rdE(rdE),
    .MemReadE(MemReadE), .PCsrcE(PCsrcE), .PCtargetE(PCtargetE),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .cnt_clr(cnt_clr),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .PCsel(PCsel), .PCredirect(PCredirect),
    .state_o(state_o), .lu_cnt(lu_cnt), .br_cnt(br_cnt), .mw_cnt(mw_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rs1D = 5'd0; rs2D = 5'd0; rdE = 5'd0;
    MemReadE = 1'b0; PCsrcE = 1'b0; PCtargetE = 32'h0;
    dmem_req = 1'b0; dmem_ready = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic loaduse_in(input logic [4:0] rd, input logic [4:0] s1, input logic [4:0] s2);
    MemReadE = 1'b1; rdE = rd; rs1D = s1; rs2D = s2;
  endtask

  // Advance to one time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    #7;
    chk("rst_state", {30'd0, state_o}, 32'd0);
    chk("rst_lu", {16'd0, lu_cnt}, 32'd0);
    chk("rst_br", {16'd0, br_cnt}, 32'd0);
    chk("rst_mw", {16'd0, mw_cnt}, 32'd0);
    PCsrcE = 1'b1; PCtargetE = 32'h40;
    #1;
    chk("rst_pcsel", {31'd0, PCsel}, 32'd0);
    chk("rst_redir", PCredirect, 32'd0);
    chk("rst_flushd", {31'd0, FlushD}, 32'd0);
    idle();
    rst = 1'b1;
    tick();

    // Load-use on rs1, then rdE=0, then load-use on rs2
    loaduse_in(5'd5, 5'd5, 5'd0);
    #1;
    chk("lu_stallf", {31'd0, StallF}, 32'd1);
    chk("lu_stalld", {31'd0, StallD}, 32'd1);
    chk("lu_flushe", {31'd0, FlushE}, 32'd1);
    chk("lu_stalle", {31'd0, StallE}, 32'd0);
    chk("lu_flushd", {31'd0, FlushD}, 32'd0);
    tick();
    idle();
    #1;
    chk("lu_cnt1", {16'd0, lu_cnt}, 32'd1);
    chk("lu_one_cycle", {31'd0, StallF}, 32'd0);
    loaduse_in(5'd0, 5'd0, 5'd0);
    #1;
    chk("lu_x0_nostall", {31'd0, StallF}, 32'd0);
    tick();
    chk("lu_x0_cnt", {16'd0, lu_cnt}, 32'd1);
    loaduse_in(5'd7, 5'd3, 5'd7);
    #1;
    chk("lu_rs2_stall", {31'd0, StallD}, 32'd1);
    tick();
    idle();
    chk("lu_cnt2", {16'd0, lu_cnt}, 32'd2);

    // Taken branch: two flush cycles, load-use suppressed during FLUSH
    PCsrcE = 1'b1; PCtargetE = 32'h40;
    #1;
    chk("br0_pcsel", {31'd0, PCsel}, 32'd1);
    chk("br0_redir", PCredirect, 32'h40);
    chk("br0_flushd", {31'd0, FlushD}, 32'd1);
    chk("br0_flushe", {31'd0, FlushE}, 32'd1);
    chk("br0_stallf", {31'd0, StallF}, 32'd0);
    tick();
    idle();
    loaduse_in(5'd5, 5'd5, 5'd0);
    #1;
    chk("br1_state", {30'd0, state_o}, 32'd1);
    chk("br1_flushd", {31'd0, FlushD}, 32'd1);
    chk("br1_flushe", {31'd0, FlushE}, 32'd1);
    chk("br1_pcsel", {31'd0, PCsel}, 32'd0);
    chk("br1_redir", PCredirect, 32'd0);
    chk("br1_no_lu", {31'd0, StallF}, 32'd0);
    chk("br1_cnt", {16'd0, br_cnt}, 32'd1);
    tick();
    idle();
    #1;
    chk("br2_state", {30'd0, state_o}, 32'd0);
    chk("br2_flushd", {31'd0, FlushD}, 32'd0);
    chk("br2_lu_cnt", {16'd0, lu_cnt}, 32'd2);

    // Branch and load-use in the same cycle: branch only
    PCsrcE = 1'b1; PCtargetE = 32'h80;
    loaduse_in(5'd5, 5'd5, 5'd0);
    #1;
    chk("bl_stallf", {31'd0, StallF}, 32'd0);
    chk("bl_stalld", {31'd0, StallD}, 32'd0);
    chk("bl_pcsel", {31'd0, PCsel}, 32'd1);
    chk("bl_redir", PCredirect, 32'h80);
    tick();
    idle();
    chk("bl_lu_cnt", {16'd0, lu_cnt}, 32'd2);
    chk("bl_br_cnt", {16'd0, br_cnt}, 32'd2);
    tick();
    chk("bl_run", {30'd0, state_o}, 32'd0);

    // Memory freeze for three cycles with a branch pending
    dmem_req = 1'b1; dmem_ready = 1'b0; PCsrcE = 1'b1; PCtargetE = 32'h100;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("mw_stallf", {31'd0, StallF}, 32'd1);
      chk("mw_stallm", {31'd0, StallM}, 32'd1);
      chk("mw_pcsel", {31'd0, PCsel}, 32'd0);
      tick();
      chk("mw_state", {30'd0, state_o}, 32'd2);
    end
    chk("mw_cnt3", {16'd0, mw_cnt}, 32'd3);
    dmem_ready = 1'b1;
    #1;
    chk("mw_exit_pcsel", {31'd0, PCsel}, 32'd1);
    chk("mw_exit_redir", PCredirect, 32'h100);
    chk("mw_exit_stalle", {31'd0, StallE}, 32'd0);
    tick();
    idle();
    chk("mw_exit_state", {30'd0, state_o}, 32'd1);
    chk("mw_exit_br", {16'd0, br_cnt}, 32'd3);
    tick();
    chk("mw_run", {30'd0, state_o}, 32'd0);

    // Branch during FLUSH restarts the countdown
    PCsrcE = 1'b1; PCtargetE = 32'h200;
    tick();
    PCtargetE = 32'h300;
    #1;
    chk("rs_pcsel", {31'd0, PCsel}, 32'd1);
    chk("rs_redir", PCredirect, 32'h300);
    tick();
    idle();
    chk("rs_state", {30'd0, state_o}, 32'd1);
    tick();
    chk("rs_run", {30'd0, state_o}, 32'd0);
    chk("rs_br", {16'd0, br_cnt}, 32'd5);

    // Freeze in FLUSH: countdown held, flush resumes after MEM_WAIT
    PCsrcE = 1'b1; PCtargetE = 32'h400;
    tick();
    idle();
    dmem_req = 1'b1;
    #1;
    chk("fz_flushd", {31'd0, FlushD}, 32'd0);
    chk("fz_stalld", {31'd0, StallD}, 32'd1);
    tick();
    dmem_ready = 1'b1;
    #1;
    chk("fz_wait_state", {30'd0, state_o}, 32'd2);
    chk("fz_exit_flush", {31'd0, FlushD}, 32'd0);
    tick();
    idle();
    #1;
    chk("fz_back_flush", {30'd0, state_o}, 32'd1);
    chk("fz_back_flushe", {31'd0, FlushE}, 32'd1);
    tick();
    chk("fz_run", {30'd0, state_o}, 32'd0);
    chk("fz_mw_cnt", {16'd0, mw_cnt}, 32'd4);

    // Asynchronous reset in the middle of FLUSH
    PCsrcE = 1'b1; PCtargetE = 32'h500;
    tick();
    idle();
    chk("ar_pre_flush", {31'd0, FlushD}, 32'd1);
    rst = 1'b0;
    #1;
    chk("ar_flushd", {31'd0, FlushD}, 32'd0);
    chk("ar_flushe", {31'd0, FlushE}, 32'd0);
    chk("ar_state", {30'd0, state_o}, 32'd0);
    chk("ar_br_cnt", {16'd0, br_cnt}, 32'd0);
    rst = 1'b1;
    tick();
    chk("ar_run", {30'd0, state_o}, 32'd0);
    chk("ar_run_flushd", {31'd0, FlushD}, 32'd0);

    // Saturate lu_cnt, then clear it while the hazard persists
    loaduse_in(5'd9, 5'd9, 5'd0);
    repeat (65537) tick();
    chk("sat_lu", {16'd0, lu_cnt}, 32'hFFFF);
    tick();
    chk("sat_hold", {16'd0, lu_cnt}, 32'hFFFF);
    cnt_clr = 1'b1;
    tick();
    chk("clr_lu", {16'd0, lu_cnt}, 32'd0);
    idle();
    tick();
    chk("clr_stay", {16'd0, lu_cnt}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
